glink_rx_frame_checker: RTL
===========================

Name: glink_rx_frame_checker

Overview:
- Receive-side checker for the 16-bit G-Link/TLK DAQ frame stream, i.e. the format the DMB transmit path drives as GOUT/TX_ENABLE toward the DDU.
- Sits on the rxclk domain behind the GLRD/GRXDAV/GRXERR input registers, used for loopback and link-integrity checks.
- Parses each frame as header, payload, then trailer; checks word count, L1A sequence, link errors and timeouts; keeps status counters for JTAG readout.

Parameters:
- MAX_WORDS, 4095: maximum payload words allowed per frame.
- TIMEOUT, 255: number of consecutive rxclk cycles with RXDAV=0 inside a frame before the frame is aborted.

Ports:
- rxclk  in  1  receive clock
- rst  in  1  asynchronous, active-high reset
- RXD  in  16  received data word, valid when RXDAV=1
- RXDAV  in  1  data-valid qualifier
- RXERR  in  1  TLK receive error, sampled every cycle
- CLR_CNT  in  1  synchronous clear of FRM_CNT and ERR_CNT
- BUSY  out  1  frame in progress (state not IDLE)
- FRAME_OK  out  1  one-cycle pulse when a frame ends cleanly
- FRAME_ERR  out  1  one-cycle pulse when a frame is aborted or ends with an error
- ERR_CODE  out  4  code of the last error, held until the next error
- L1A_NUM  out  12  L1A number from the last accepted header
- WORD_CNT  out  12  payload word count of the last completed frame
- FRM_CNT  out  16  good-frame counter, saturating
- ERR_CNT  out  16  error counter, saturating

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. The internal L1A-valid flag is 0 and the state is IDLE.
- A word is consumed only on an rxclk edge where RXDAV=1. Nothing advances while RXDAV=0.
- Frame format:
  - 4 header words with RXD[15:12]=4'h9. Header word 0 carries L1A[11:0].
  - 4 header words with RXD[15:12]=4'hA.
  - 0..MAX_WORDS payload words of any value except RXD[15:12]=4'hF.
  - 4 trailer words with RXD[15:12]=4'hF.
  - 4 trailer words with RXD[15:12]=4'hE. Word 3 of this group carries the payload count in [11:0].
- States: IDLE, HDR9, HDRA, PAYLOAD, TRLF, TRLE.
  - A 2-bit index counts words within each 4-word group.
  - A 12-bit counter counts payload words.
- Transitions:
  - IDLE: a 9xxx word latches L1A, index=1, go to HDR9. Any other word is discarded, with no error raised.
  - HDR9 and HDRA: a word with the wrong nibble gives error 1 and a return to IDLE. After the 4th word, move to the next state.
  - PAYLOAD: an Fxxx word moves to TRLF with index=1. Any other word increments the payload counter. Reaching count > MAX_WORDS gives error 2 and a return to IDLE.
  - TRLF and TRLE: a wrong nibble gives error 3 and a return to IDLE.
  - Last E word: if [11:0] is not equal to the payload count, error 4. Otherwise the frame completes and the state returns to IDLE.
- Frame completion:
  - WORD_CNT is updated at completion, for both good frames and error 4.
  - L1A check: when the L1A-valid flag is 1 and the header L1A is not equal to the previous L1A+1 (mod 4096), the completion reports error 7 instead of OK.
  - Every completed frame (OK or error 4/7) updates L1A_NUM and sets the L1A-valid flag.
  - Aborted frames update neither.
- RXERR=1 in any non-IDLE state gives error 5 and a return to IDLE. This takes priority over the word being processed on the same edge. RXERR in IDLE is ignored.
- Timeout:
  - The idle counter resets on every RXDAV=1 and on entry to IDLE.
  - When it reaches TIMEOUT in a non-IDLE state, error 6 and a return to IDLE.
  - Priority, highest first: 5, 6, then word-based errors.
- Reporting:
  - FRAME_OK or FRAME_ERR pulses for exactly one cycle, in the cycle after the edge that sampled the terminating word or event. The two are never asserted together.
  - Each error pulse loads ERR_CODE and increments ERR_CNT. Each OK increments FRM_CNT.
  - Both counters saturate at 16'hFFFF.
- CLR_CNT zeroes both counters. It wins over a same-cycle increment.
- Asynchronous rst in the middle of a frame returns everything to the reset values immediately. The next frame's L1A is not sequence-checked.

Test Plan:
- Good frame with L1A=12'h005, 3 payload words and E-word 3 = 12'h003 -> one FRAME_OK pulse; FRM_CNT=1, WORD_CNT=3, L1A_NUM=12'h005, ERR_CNT=0.
- Second good frame with L1A=12'h007 after frame 1 -> FRAME_ERR, ERR_CODE=7, L1A_NUM=12'h007. Third frame with L1A=12'h008 -> FRAME_OK. Also cover the wrap case 12'hFFF followed by 12'h000 -> OK.
- RXERR pulsed during the 2nd payload word -> FRAME_ERR next cycle, ERR_CODE=5, BUSY=0; a following good frame -> OK.
- RXDAV held low for 255 cycles in PAYLOAD (default TIMEOUT) -> FRAME_ERR, ERR_CODE=6. With a 254-cycle gap then resumption -> no error.
- Header sequence 9,9,9,A -> ERR_CODE=1. Count mismatch (3 payload words, trailer field 4) -> ERR_CODE=4 with WORD_CNT=3. With MAX_WORDS=8, 9 payload words -> ERR_CODE=2.
- Counter boundaries: ERR_CNT preloaded to 16'hFFFF plus another error -> stays at 16'hFFFF. CLR_CNT on the same edge as FRAME_OK -> FRM_CNT=0. rst mid-frame -> all outputs 0, and the next frame's L1A is accepted with no error 7.

Source files
------------

// File: rtl/glink_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : glink_rx_frame_checker
// Brief    : Receive-side checker for the 16-bit G-Link/TLK DAQ frame stream.
//            Parses header (4x 9xxx, 4x Axxx), payload, trailer (4x Fxxx,
//            4x Exxx); checks word count, L1A sequence, link errors and
//            inter-word timeouts; keeps saturating status counters.
// Revision : 1.0 - initial release
// ============================================================================
module glink_rx_frame_checker #(
    parameter int MAX_WORDS = 4095,
    parameter int TIMEOUT   = 255
) (
    input  logic        rxclk,
    input  logic        rst,
    input  logic [15:0] RXD,
    input  logic        RXDAV,
    input  logic        RXERR,
    input  logic        CLR_CNT,
    output logic        BUSY,
    output logic        FRAME_OK,
    output logic        FRAME_ERR,
    output logic [3:0]  ERR_CODE,
    output logic [11:0] L1A_NUM,
    output logic [11:0] WORD_CNT,
    output logic [15:0] FRM_CNT,
    output logic [15:0] ERR_CNT
);

    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [11:0]       MAX_CNT   = 12'(MAX_WORDS);

    localparam logic [3:0] ERR_HDR     = 4'd1;
    localparam logic [3:0] ERR_LEN     = 4'd2;
    localparam logic [3:0] ERR_TRL     = 4'd3;
    localparam logic [3:0] ERR_CNTMIS  = 4'd4;
    localparam logic [3:0] ERR_LINK    = 4'd5;
    localparam logic [3:0] ERR_TIMEOUT = 4'd6;
    localparam logic [3:0] ERR_L1A     = 4'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR9    = 3'd1,
        HDRA    = 3'd2,
        PAYLOAD = 3'd3,
        TRLF    = 3'd4,
        TRLE    = 3'd5
    } state_t;

    state_t              r_state, w_state_n;
    logic [1:0]          r_idx, w_idx_n;
    logic [11:0]         r_pcnt, w_pcnt_n;
    logic [11:0]         r_hdr_l1a, w_hdr_l1a_n;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_l1a_valid;
    logic                w_ok, w_err, w_done;
    logic [3:0]          w_code;
    logic [3:0]          w_nib;
    logic [15:0]         w_frm_next, w_err_next;

    assign w_nib = RXD[15:12];

    // Next-state and event decode; link error beats timeout beats word checks
    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_pcnt_n    = r_pcnt;
        w_hdr_l1a_n = r_hdr_l1a;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_code      = 4'd0;
        if (r_state != IDLE && RXERR) begin
            w_err     = 1'b1;
            w_code    = ERR_LINK;
            w_state_n = IDLE;
        end else if (r_state != IDLE && !RXDAV && r_idle == IDLE_LAST) begin
            w_err     = 1'b1;
            w_code    = ERR_TIMEOUT;
            w_state_n = IDLE;
        end else if (RXDAV) begin
            case (r_state)
                IDLE: begin
                    if (w_nib == 4'h9) begin
                        w_hdr_l1a_n = RXD[11:0];
                        w_idx_n     = 2'd1;
                        w_state_n   = HDR9;
                    end
                end
                HDR9, HDRA: begin
                    if (w_nib != ((r_state == HDR9) ? 4'h9 : 4'hA)) begin
                        w_err     = 1'b1;
                        w_code    = ERR_HDR;
                        w_state_n = IDLE;
                    end else if (r_idx == 2'd3) begin
                        w_idx_n   = 2'd0;
                        w_pcnt_n  = 12'd0;
                        w_state_n = (r_state == HDR9) ? HDRA : PAYLOAD;
                    end else begin
                        w_idx_n = r_idx + 2'd1;
                    end
                end
                PAYLOAD: begin
                    if (w_nib == 4'hF) begin
                        w_idx_n   = 2'd1;
                        w_state_n = TRLF;
                    end else if (r_pcnt == MAX_CNT) begin
                        w_err     = 1'b1;
                        w_code    = ERR_LEN;
                        w_state_n = IDLE;
                    end else begin
                        w_pcnt_n = r_pcnt + 12'd1;
                    end
                end
                TRLF, TRLE: begin
                    if (w_nib != ((r_state == TRLF) ? 4'hF : 4'hE)) begin
                        w_err     = 1'b1;
                        w_code    = ERR_TRL;
                        w_state_n = IDLE;
                    end else if (r_idx != 2'd3) begin
                        w_idx_n = r_idx + 2'd1;
                    end else if (r_state == TRLF) begin
                        w_idx_n   = 2'd0;
                        w_state_n = TRLE;
                    end else begin
                        // Last E word: frame completes, possibly with an error
                        w_done    = 1'b1;
                        w_state_n = IDLE;
                        if (RXD[11:0] != r_pcnt) begin
                            w_err  = 1'b1;
                            w_code = ERR_CNTMIS;
                        end else if (r_l1a_valid && r_hdr_l1a != L1A_NUM + 12'd1) begin
                            w_err  = 1'b1;
                            w_code = ERR_L1A;
                        end else begin
                            w_ok = 1'b1;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // Saturating counter next values; clear overrides an increment
    always_comb begin
        w_frm_next = FRM_CNT;
        w_err_next = ERR_CNT;
        if (CLR_CNT) begin
            w_frm_next = 16'd0;
            w_err_next = 16'd0;
        end else begin
            if (w_ok && FRM_CNT != 16'hFFFF) w_frm_next = FRM_CNT + 16'd1;
            if (w_err && ERR_CNT != 16'hFFFF) w_err_next = ERR_CNT + 16'd1;
        end
    end

    // Parser state, word counters and the inter-word gap counter
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_pcnt      <= 12'd0;
            r_hdr_l1a   <= 12'd0;
            r_idle      <= '0;
            r_l1a_valid <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_pcnt    <= w_pcnt_n;
            r_hdr_l1a <= w_hdr_l1a_n;
            r_idle    <= (RXDAV || w_state_n == IDLE) ? '0 : r_idle + 1'b1;
            if (w_done) r_l1a_valid <= 1'b1;
        end
    end

    // Registered status outputs and counters
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            BUSY      <= 1'b0;
            FRAME_OK  <= 1'b0;
            FRAME_ERR <= 1'b0;
            ERR_CODE  <= 4'd0;
            L1A_NUM   <= 12'd0;
            WORD_CNT  <= 12'd0;
            FRM_CNT   <= 16'd0;
            ERR_CNT   <= 16'd0;
        end else begin
            BUSY      <= (w_state_n != IDLE);
            FRAME_OK  <= w_ok;
            FRAME_ERR <= w_err;
            if (w_err) ERR_CODE <= w_code;
            if (w_done) begin
                L1A_NUM  <= r_hdr_l1a;
                WORD_CNT <= r_pcnt;
            end
            FRM_CNT   <= w_frm_next;
            ERR_CNT   <= w_err_next;
        end
    end

endmodule
`default_nettype wire
